// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
//   Shared definitions for the param_stack block:
//     - default entry width and depth
//     - stack operation enum, encoded directly as {push, pop}
//     - decode_op(): maps the raw push/pop request pair onto the enum
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 20;

    // Encoding is {push, pop} so the request pair casts straight onto the enum.
    typedef enum logic [1:0] {
        NOP     = 2'b00,
        POP     = 2'b01,
        PUSH    = 2'b10,
        REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_mem.sv
// -----------------------------------------------------------------------------
// stack_mem
//   Entry storage for param_stack: one synchronous write port and one
//   combinational read port.
//
//   Ports
//     clk    in   clock, write happens on its rising edge
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array deliberately has no reset; the occupancy count alone
    // decides which entries are meaningful, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// -----------------------------------------------------------------------------
// param_stack
//   LIFO stack of DEPTH entries, DATA_W bits wide. Entries are stored at
//   descending addresses: the next free slot is DEPTH-1-count and the current
//   top entry sits at DEPTH-count. A popped value is returned one clock later
//   on either the register path or the PC path, selected by dest_pc.
//
//   Operations, decoded from {push, pop} each cycle:
//     NOP      no change
//     PUSH     write push_data at the free slot (rejected when full -> ovf)
//     POP      return top entry, drop it (rejected when empty -> unf)
//     REPLACE  return top entry and overwrite it with push_data; when empty
//              behaves as PUSH and also raises unf
//
//   Ports
//     clk         in   clock
//     rst         in   asynchronous active-high reset
//     push, pop   in   operation request
//     dest_pc     in   pop destination: 0 register path, 1 PC path
//     push_data   in   data to push
//     reg_data    out  last value popped to the register path (held)
//     reg_valid   out  one-cycle strobe for reg_data
//     pc_data     out  last value popped to the PC path (held)
//     pc_valid    out  one-cycle strobe for pc_data
//     count       out  occupancy, 0..DEPTH
//     full/empty  out  count==DEPTH / count==0
//     ovf/unf     out  one-cycle pulses: push rejected / pop rejected
//     err_clr     in   clears the sticky error bits
//     err_sticky  out  sticky {ovf, unf}
//
//   Configuration
//     STACK_ERR_STICKY_EN  when defined, err_sticky latches ovf/unf events
//                          until err_clr or rst (a set wins over a clear in
//                          the same cycle). When undefined, err_sticky is
//                          tied to 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              dest_pc,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_valid,
    output logic [DATA_W-1:0] pc_data,
    output logic              pc_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf,
    input  logic              err_clr,
    output logic [1:0]        err_sticky
);

    localparam int              ADDR_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    stack_op_e         op;
    logic [ADDR_W-1:0] top_addr;
    logic [ADDR_W-1:0] free_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  count_nxt;
    logic              pop_ok;
    logic              ovf_set;
    logic              unf_set;

    // ------------------------------------------------------------------
    // Status flags and addresses derived from the occupancy count
    // ------------------------------------------------------------------
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // top_addr is only used when the stack is not empty, and free_addr only
    // when it is not full, so the out-of-range corner values never matter.
    assign top_addr  = ADDR_W'(DEPTH_C - count);
    assign free_addr = ADDR_W'(DEPTH_C - ONE_C - count);

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        op        = decode_op(push, pop);
        mem_we    = 1'b0;
        mem_waddr = free_addr;
        count_nxt = count;
        pop_ok    = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        case (op)
            PUSH: begin
                if (!full) begin
                    mem_we    = 1'b1;
                    count_nxt = count + ONE_C;
                end else begin
                    ovf_set   = 1'b1;
                end
            end
            POP: begin
                if (!empty) begin
                    pop_ok    = 1'b1;
                    count_nxt = count - ONE_C;
                end else begin
                    unf_set   = 1'b1;
                end
            end
            REPLACE: begin
                if (!empty) begin
                    // Old top is read combinationally this cycle and the
                    // same slot is overwritten at the edge.
                    pop_ok    = 1'b1;
                    mem_we    = 1'b1;
                    mem_waddr = top_addr;
                end else begin
                    // Nothing to return: degrade to a push and flag it.
                    mem_we    = 1'b1;
                    count_nxt = count + ONE_C;
                    unf_set   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Storage. Writes are suppressed while rst is high so an operation
    // presented during reset leaves no trace in memory either.
    // ------------------------------------------------------------------
    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & ~rst),
        .waddr (mem_waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (mem_rdata)
    );

    // ------------------------------------------------------------------
    // Occupancy, pop results and error pulses
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            reg_data  <= '0;
            reg_valid <= 1'b0;
            pc_data   <= '0;
            pc_valid  <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            count     <= count_nxt;
            reg_valid <= pop_ok & ~dest_pc;
            pc_valid  <= pop_ok &  dest_pc;
            // The non-selected path keeps its last popped value.
            if (pop_ok && !dest_pc) begin
                reg_data <= mem_rdata;
            end
            if (pop_ok && dest_pc) begin
                pc_data <= mem_rdata;
            end
            ovf       <= ovf_set;
            unf       <= unf_set;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error capture
    // ------------------------------------------------------------------
`ifdef STACK_ERR_STICKY_EN
    logic [1:0] sticky_q;

    // The bits rise on the same edge as the ovf/unf pulses; a new event in
    // the clearing cycle keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q[1] <= ovf_set | (sticky_q[1] & ~err_clr);
            sticky_q[0] <= unf_set | (sticky_q[0] & ~err_clr);
        end
    end

    assign err_sticky = sticky_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_sticky     = 2'b00;
`endif

endmodule

// File: tb/tb_param_stack.sv
// -----------------------------------------------------------------------------
// tb_param_stack
//   Self-checking bench for param_stack (default parameters). A queue-based
//   reference model tracks the stack contents and expected outputs; a compare
//   process checks every DUT output against it on each falling edge. Directed
//   sequences with literal expectations pin the model, followed by a biased
//   random phase and a mid-sequence asynchronous reset.
// -----------------------------------------------------------------------------
module tb_param_stack;
    import stack_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 20;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              push;
    logic              pop;
    logic              dest_pc;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] reg_data;
    logic              reg_valid;
    logic [DATA_W-1:0] pc_data;
    logic              pc_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;
    logic              err_clr;
    logic [1:0]        err_sticky;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    param_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .dest_pc    (dest_pc),
        .push_data  (push_data),
        .reg_data   (reg_data),
        .reg_valid  (reg_valid),
        .pc_data    (pc_data),
        .pc_valid   (pc_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .unf        (unf),
        .err_clr    (err_clr),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue whose back is the top of stack
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mq [$];
    logic [DATA_W-1:0] m_reg_data, m_pc_data, m_v;
    logic              m_reg_valid, m_pc_valid, m_ovf, m_unf, m_deliver;
    logic [1:0]        m_sticky;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_reg_data  = '0;
            m_pc_data   = '0;
            m_reg_valid = 1'b0;
            m_pc_valid  = 1'b0;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            m_sticky    = 2'b00;
        end else begin
            m_ovf     = 1'b0;
            m_unf     = 1'b0;
            m_deliver = 1'b0;
            m_v       = '0;
            if (push && !pop) begin
                if (mq.size() < DEPTH) mq.push_back(push_data);
                else m_ovf = 1'b1;
            end else if (!push && pop) begin
                if (mq.size() > 0) begin
                    m_v = mq.pop_back();
                    m_deliver = 1'b1;
                end else m_unf = 1'b1;
            end else if (push && pop) begin
                if (mq.size() > 0) begin
                    m_v = mq[mq.size()-1];
                    mq[mq.size()-1] = push_data;
                    m_deliver = 1'b1;
                end else begin
                    mq.push_back(push_data);
                    m_unf = 1'b1;
                end
            end
            m_reg_valid = m_deliver && !dest_pc;
            m_pc_valid  = m_deliver &&  dest_pc;
            if (m_reg_valid) m_reg_data = m_v;
            if (m_pc_valid)  m_pc_data  = m_v;
`ifdef STACK_ERR_STICKY_EN
            m_sticky[1] = m_ovf || (m_sticky[1] && !err_clr);
            m_sticky[0] = m_unf || (m_sticky[0] && !err_clr);
`else
            m_sticky = 2'b00;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every falling edge outside reset
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("count",      32'(count),      32'(mq.size()));
            check("full",       32'(full),       32'(mq.size() == DEPTH));
            check("empty",      32'(empty),      32'(mq.size() == 0));
            check("reg_valid",  32'(reg_valid),  32'(m_reg_valid));
            check("pc_valid",   32'(pc_valid),   32'(m_pc_valid));
            check("reg_data",   32'(reg_data),   32'(m_reg_data));
            check("pc_data",    32'(pc_data),    32'(m_pc_data));
            check("ovf",        32'(ovf),        32'(m_ovf));
            check("unf",        32'(unf),        32'(m_unf));
            check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        end
    end

    // Called just after a falling edge; returns at the next falling edge
    // with the outputs for this operation settled.
    task automatic step(input logic p, input logic o, input logic dp,
                        input logic [DATA_W-1:0] d, input logic clr);
        push      = p;
        pop       = o;
        dest_pc   = dp;
        push_data = d;
        err_clr   = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; dest_pc = 1'b0; push_data = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_reg_data", 32'(reg_data), 32'd0);

        // Basic push/pop to the register path
        step(1, 0, 0, 16'h1111, 0);
        step(1, 0, 0, 16'h2222, 0);
        check("push2_count", 32'(count), 32'd2);
        step(0, 1, 0, 16'h0000, 0);
        check("pop_reg_data",  32'(reg_data),  32'h2222);
        check("pop_reg_valid", 32'(reg_valid), 32'd1);
        check("pop_count",     32'(count),     32'd1);

        // PC path, register path holds
        step(1, 0, 0, 16'hABCD, 0);
        step(0, 1, 1, 16'h0000, 0);
        check("pc_data",       32'(pc_data),   32'hABCD);
        check("pc_valid",      32'(pc_valid),  32'd1);
        check("pc_reg_hold",   32'(reg_data),  32'h2222);
        step(0, 0, 0, 16'h0000, 0);
        check("pc_valid_drop", 32'(pc_valid),  32'd0);
        step(0, 1, 0, 16'h0000, 0);
        check("drain_1111",    32'(reg_data),  32'h1111);

        // Fill, overflow, LIFO drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 16'(16'h1000 + i), 0);
        step(1, 0, 0, 16'hDEAD, 0);
        check("ovf_pulse", 32'(ovf),   32'd1);
        check("ovf_count", 32'(count), 32'd20);
        check("ovf_full",  32'(full),  32'd1);
        step(0, 0, 0, 16'h0000, 0);
        check("ovf_drop",  32'(ovf),   32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, i[0], 16'h0000, 0);
            if (i[0]) check("lifo_pc",  32'(pc_data),  32'(16'h1000 + DEPTH - 1 - i));
            else      check("lifo_reg", 32'(reg_data), 32'(16'h1000 + DEPTH - 1 - i));
        end
        check("lifo_empty", 32'(empty), 32'd1);

        // Underflow and sticky behaviour
        step(0, 0, 0, 16'h0000, 1);
        step(0, 1, 0, 16'h0000, 0);
        check("unf_pulse",   32'(unf),       32'd1);
        check("unf_novalid", 32'({reg_valid, pc_valid}), 32'd0);
        check("unf_count",   32'(count),     32'd0);
`ifdef STACK_ERR_STICKY_EN
        check("sticky_set",  32'(err_sticky), 32'd1);
        step(0, 0, 0, 16'h0000, 0);
        check("sticky_hold", 32'(err_sticky), 32'd1);
        step(0, 0, 0, 16'h0000, 1);
        check("sticky_clr",  32'(err_sticky), 32'd0);
        step(0, 1, 0, 16'h0000, 1);
        check("sticky_set_wins", 32'(err_sticky), 32'd1);
`else
        step(0, 1, 0, 16'h0000, 1);
        check("sticky_off",  32'(err_sticky), 32'd0);
`endif
        step(0, 0, 0, 16'h0000, 1);

        // Replace
        step(1, 0, 0, 16'h0005, 0);
        step(1, 1, 0, 16'h0009, 0);
        check("repl_reg_data", 32'(reg_data), 32'h0005);
        check("repl_count",    32'(count),    32'd1);
        step(0, 1, 1, 16'h0000, 0);
        check("repl_next_pop", 32'(pc_data),  32'h0009);
        step(1, 1, 0, 16'h0077, 0);
        check("repl_empty_unf",   32'(unf),   32'd1);
        check("repl_empty_count", 32'(count), 32'd1);
        check("repl_empty_novld", 32'(reg_valid), 32'd0);
        step(0, 1, 0, 16'h0000, 0);
        check("repl_empty_pop", 32'(reg_data), 32'h0077);

        // Randomized phase, alternating push-heavy and pop-heavy windows
        for (int i = 0; i < 800; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
                 1'($urandom_range(0, 1)), 16'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-sequence with 7 entries
        while (count != 0) step(0, 1, 0, 16'h0000, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 16'(16'h0700 + i), 0);
        step(1, 1, 1, 16'h0055, 0);
        step(0, 1, 0, 16'h0000, 0);
        step(1, 0, 0, 16'h0099, 0);
        check("pre_rst_count", 32'(count), 32'd7);
        #2 rst = 1'b1;
        push = 1'b1; push_data = 16'hBEEF;
        #1;
        check("rst_mid_count",   32'(count),    32'd0);
        check("rst_mid_empty",   32'(empty),    32'd1);
        check("rst_mid_data",    32'({reg_data, pc_data}), 32'd0);
        check("rst_mid_valids",  32'({reg_valid, pc_valid, ovf, unf}), 32'd0);
        check("rst_mid_sticky",  32'(err_sticky), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 16'h4242, 0);
        check("post_rst_count", 32'(count), 32'd1);
        step(0, 1, 0, 16'h0000, 0);
        check("post_rst_pop",   32'(reg_data), 32'h4242);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
